// File: rtl/kbd_fifo_wb.sv
// Keyboard key buffer with a bus-mapped status/data register pair, two interrupt
// vectors (60 / 274) and a hardware auto-repeat engine.
module kbd_fifo_wb #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [23:0] REP_DELAY  = 24'd12000000,
  parameter logic [23:0] REP_RATE   = 24'd2000000,
  parameter logic [15:0] BASE_ADDR  = 16'o177660
) (
  input  logic                          clk_bus,
  input  logic                          bus_reset,
  input  logic [15:0]                   bus_din,
  output logic [15:0]                   bus_dout,
  input  logic [15:0]                   bus_addr,
  input  logic                          bus_sync,
  input  logic                          bus_we,
  input  logic                          bus_stb,
  output logic                          bus_ack,
  output logic                          virq_req60,
  input  logic                          virq_ack60,
  output logic                          virq_req274,
  input  logic                          virq_ack274,
  input  logic                          key_strobe,
  input  logic [6:0]                    key_code,
  input  logic                          key_ar2,
  input  logic                          key_held,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DataAddr = BASE_ADDR + 16'd2;
  localparam logic [AW:0] DepthLvl = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StDelay, StRate} rep_state_e;

  // Key buffer storage and pointers
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;

  // Register file
  logic        ovf_q, imask_q, rep_en_q;
  logic [15:0] data_o_q;
  logic [6:0]  last_code_q;

  // Bus edge detection
  logic ack_q, stb_st_q, stb_dt_q;
  logic ack60_q, ack274_q;
  logic req60_q, req274_q;

  // Auto-repeat engine
  rep_state_e  rep_state_q;
  logic [23:0] rep_cnt_q;
  logic [7:0]  rep_entry_q;

  logic        sel_st, sel_dt, stb_st, stb_dt;
  logic        st_rise, dt_rise, st_wr, st_rd;
  logic        empty, full, pop;
  logic [7:0]  head;
  logic        key_push, rep_active, rep_fire;
  logic        push_req, push_ok, push_drop;
  logic [7:0]  push_data;
  logic [15:0] status;
  logic        mask_now;
  logic        unused_bits;

  assign sel_st = bus_sync & (bus_addr[15:1] == BASE_ADDR[15:1]);
  assign sel_dt = bus_sync & (bus_addr[15:1] == DataAddr[15:1]) & ~bus_we;
  assign stb_st = bus_stb & sel_st;
  assign stb_dt = bus_stb & sel_dt;

  assign st_rise = stb_st & ~stb_st_q;
  assign dt_rise = stb_dt & ~stb_dt_q;
  assign st_wr   = st_rise & bus_we;
  assign st_rd   = st_rise & ~bus_we;

  assign empty = (level_q == '0);
  assign full  = (level_q == DepthLvl);
  assign head  = mem_q[rd_ptr_q];
  assign pop   = dt_rise & ~empty;

  assign key_push   = key_strobe & (key_code != 7'd0);
  assign rep_active = key_held & rep_en_q;
  assign rep_fire   = rep_active & (rep_state_q != StIdle) & (rep_cnt_q == 24'd0);

  // A key push takes the write port; a coincident repeat is simply lost.
  assign push_req  = key_push | rep_fire;
  assign push_data = key_push ? {key_ar2, key_code} : rep_entry_q;
  assign push_ok   = push_req & (~full | pop);
  assign push_drop = push_req & full & ~pop;

  assign status = {ovf_q, 7'b0, ~empty, imask_q, 2'b0, rep_en_q, 3'b0};

  assign mask_now = imask_q | (st_wr & bus_din[6]);

  assign bus_dout    = (sel_st | sel_dt) ? data_o_q : 16'd0;
  assign bus_ack     = bus_stb & (sel_st | sel_dt) & ack_q;
  assign virq_req60  = req60_q;
  assign virq_req274 = req274_q;
  assign fifo_level  = level_q;

  assign unused_bits = ^{bus_din[15:7], bus_din[5:4], bus_din[2:0], bus_addr[0]};

  // Buffer contents survive reset; only the pointers are cleared.
  always_ff @(posedge clk_bus) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointers, level, register file and bus strobe history
  always_ff @(posedge clk_bus) begin
    if (bus_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      imask_q     <= 1'b1;
      rep_en_q    <= 1'b1;
      data_o_q    <= 16'd0;
      last_code_q <= 7'd0;
      ack_q       <= 1'b0;
      stb_st_q    <= 1'b0;
      stb_dt_q    <= 1'b0;
    end else begin
      ack_q    <= bus_stb;
      stb_st_q <= stb_st;
      stb_dt_q <= stb_dt;
      if (st_wr) begin
        imask_q  <= bus_din[6];
        rep_en_q <= bus_din[3];
      end
      if (st_rd) begin
        data_o_q <= status;
        ovf_q    <= 1'b0;
      end
      // A drop in the same cycle as a status read must not be lost.
      if (push_drop) ovf_q <= 1'b1;
      if (dt_rise) begin
        if (!empty) begin
          data_o_q    <= {9'b0, head[6:0]};
          last_code_q <= head[6:0];
        end else begin
          data_o_q <= {9'b0, last_code_q};
        end
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)      level_q <= level_q + (AW + 1)'(1);
      else if (!push_ok && pop) level_q <= level_q - (AW + 1)'(1);
    end
  end

  // Interrupt requests: raise one cycle after the arming condition, clear on ack/read/mask
  always_ff @(posedge clk_bus) begin
    if (bus_reset) begin
      req60_q  <= 1'b0;
      req274_q <= 1'b0;
      ack60_q  <= 1'b0;
      ack274_q <= 1'b0;
    end else begin
      ack60_q  <= virq_ack60;
      ack274_q <= virq_ack274;
      if (mask_now || dt_rise) begin
        req60_q  <= 1'b0;
        req274_q <= 1'b0;
      end else begin
        if (virq_ack60 && !ack60_q)   req60_q  <= 1'b0;
        if (virq_ack274 && !ack274_q) req274_q <= 1'b0;
        if (!req60_q && !req274_q && !empty) begin
          if (head[7]) req274_q <= 1'b1;
          else         req60_q  <= 1'b1;
        end
      end
    end
  end

  // Auto-repeat FSM: initial delay, then fixed-rate re-pushes while the key is held
  always_ff @(posedge clk_bus) begin
    if (bus_reset) begin
      rep_state_q <= StIdle;
      rep_cnt_q   <= 24'd0;
      rep_entry_q <= 8'd0;
    end else if (!rep_active) begin
      rep_state_q <= StIdle;
      rep_cnt_q   <= 24'd0;
    end else if (key_push && push_ok) begin
      rep_state_q <= StDelay;
      rep_cnt_q   <= REP_DELAY - 24'd1;
      rep_entry_q <= {key_ar2, key_code};
    end else begin
      case (rep_state_q)
        StDelay, StRate: begin
          if (rep_cnt_q == 24'd0) begin
            rep_cnt_q   <= REP_RATE - 24'd1;
            rep_state_q <= StRate;
          end else begin
            rep_cnt_q <= rep_cnt_q - 24'd1;
          end
        end
        default: rep_state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_fifo_wb.sv
// Scoreboard bench for kbd_fifo_wb: pushed codes are queued, popped on data reads.
module tb_kbd_fifo_wb;

  localparam logic [15:0] StAddr = 16'o177660;
  localparam logic [15:0] DtAddr = 16'o177662;

  logic        clk_bus = 1'b0;
  logic        bus_reset = 1'b1;
  logic [15:0] bus_din = '0, bus_addr = '0;
  logic        bus_sync = 0, bus_we = 0, bus_stb = 0;
  logic [15:0] bus_dout;
  logic        bus_ack;
  logic        virq_req60, virq_req274;
  logic        virq_ack60 = 0, virq_ack274 = 0;
  logic        key_strobe = 0, key_ar2 = 0, key_held = 0;
  logic [6:0]  key_code = '0;
  logic [3:0]  fifo_level;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  kbd_fifo_wb #(
    .FIFO_DEPTH(8),
    .REP_DELAY (24'd10),
    .REP_RATE  (24'd4),
    .BASE_ADDR (16'o177660)
  ) dut (
    .clk_bus    (clk_bus),
    .bus_reset  (bus_reset),
    .bus_din    (bus_din),
    .bus_dout   (bus_dout),
    .bus_addr   (bus_addr),
    .bus_sync   (bus_sync),
    .bus_we     (bus_we),
    .bus_stb    (bus_stb),
    .bus_ack    (bus_ack),
    .virq_req60 (virq_req60),
    .virq_ack60 (virq_ack60),
    .virq_req274(virq_req274),
    .virq_ack274(virq_ack274),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .key_ar2    (key_ar2),
    .key_held   (key_held),
    .fifo_level (fifo_level)
  );

  always #5 clk_bus = ~clk_bus;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_bus);
    #1;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [15:0] data, output bit ok);
    bus_sync = 1; bus_addr = addr; bus_we = 0; bus_stb = 1;
    ok = 0; data = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus_ack) begin ok = 1; data = bus_dout; break; end
    end
    bus_stb = 0; bus_sync = 0; bus_addr = '0;
    tick();
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data, output bit ok);
    bus_sync = 1; bus_addr = addr; bus_we = 1; bus_stb = 1; bus_din = data;
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus_ack) begin ok = 1; break; end
    end
    bus_stb = 0; bus_sync = 0; bus_we = 0; bus_addr = '0; bus_din = '0;
    tick();
  endtask

  task automatic push_key(input logic [6:0] code, input logic ar2);
    key_strobe = 1; key_code = code; key_ar2 = ar2;
    tick();
    key_strobe = 0; key_code = '0; key_ar2 = 0;
  endtask

  task automatic test_reset();
    logic [15:0] d; bit ok;
    bus_reset = 1; tick(); tick(); bus_reset = 0;
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (virq_req60 !== 1'b0 || virq_req274 !== 1'b0) begin failures++; $display("FAIL reset_req got=%b%b exp=00", virq_req60, virq_req274); end
    checks++; if (bus_dout !== 16'd0 || bus_ack !== 1'b0) begin failures++; $display("FAIL reset_bus dout=%h ack=%b exp=0000/0", bus_dout, bus_ack); end
    // IMASK=1, REP_EN=1, FIFO empty
    bus_read(StAddr, d, ok);
    checks++; if (!ok || d !== 16'h0048) begin failures++; $display("FAIL reset_status ok=%0d got=%h exp=0048", ok, d); end
  endtask

  task automatic test_fifo_order();
    logic [15:0] d; logic [7:0] e; bit ok;
    push_key(7'h41, 0); sb.push_back(8'h41);
    push_key(7'h42, 0); sb.push_back(8'h42);
    checks++; if (fifo_level !== 4'd2) begin failures++; $display("FAIL order_level got=%0d exp=2", fifo_level); end
    // RDY | IMASK | REP_EN
    bus_read(StAddr, d, ok);
    checks++; if (!ok || d !== 16'h00C8) begin failures++; $display("FAIL order_status_full ok=%0d got=%h exp=00C8", ok, d); end
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      bus_read(DtAddr, d, ok);
      checks++; if (!ok || d !== {9'b0, e[6:0]}) begin failures++; $display("FAIL order_data%0d ok=%0d got=%h exp=%h", i, ok, d, {9'b0, e[6:0]}); end
    end
    bus_read(StAddr, d, ok);
    checks++; if (!ok || d !== 16'h0048) begin failures++; $display("FAIL order_status_empty ok=%0d got=%h exp=0048", ok, d); end
    bus_read(DtAddr, d, ok);
    checks++; if (!ok || d !== 16'h0042) begin failures++; $display("FAIL order_empty_read ok=%0d got=%h exp=0042", ok, d); end
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL order_empty_level got=%0d exp=0", fifo_level); end
    bus_write(DtAddr, 16'h0055, ok);
    checks++; if (ok !== 1'b0 || fifo_level !== 4'd0) begin failures++; $display("FAIL order_data_write ack=%0d level=%0d exp=0/0", ok, fifo_level); end
  endtask

  task automatic test_irq();
    logic [15:0] d; logic [7:0] e; bit ok;
    bus_write(StAddr, 16'h0008, ok);
    checks++; if (!ok) begin failures++; $display("FAIL irq_unmask_ack got=0 exp=1"); end
    push_key(7'h61, 1); sb.push_back(8'hE1);
    checks++; if (virq_req274 !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", virq_req274); end
    tick();
    checks++; if (virq_req274 !== 1'b1 || virq_req60 !== 1'b0) begin failures++; $display("FAIL irq_raise274 got=%b%b exp=01", virq_req60, virq_req274); end
    virq_ack274 = 1; tick();
    checks++; if (virq_req274 !== 1'b0) begin failures++; $display("FAIL irq_ack_clear got=%b exp=0", virq_req274); end
    virq_ack274 = 0; tick();
    checks++; if (virq_req274 !== 1'b1) begin failures++; $display("FAIL irq_rearm got=%b exp=1", virq_req274); end
    e = sb.pop_front();
    bus_read(DtAddr, d, ok);
    checks++; if (!ok || d !== {9'b0, e[6:0]}) begin failures++; $display("FAIL irq_data ok=%0d got=%h exp=%h", ok, d, {9'b0, e[6:0]}); end
    checks++; if (virq_req274 !== 1'b0 || virq_req60 !== 1'b0) begin failures++; $display("FAIL irq_read_clear got=%b%b exp=00", virq_req60, virq_req274); end
    push_key(7'h62, 0); sb.push_back(8'h62);
    tick();
    checks++; if (virq_req60 !== 1'b1 || virq_req274 !== 1'b0) begin failures++; $display("FAIL irq_raise60 got=%b%b exp=10", virq_req60, virq_req274); end
    bus_write(StAddr, 16'h0048, ok);
    checks++; if (!ok || virq_req60 !== 1'b0) begin failures++; $display("FAIL irq_mask_drop ok=%0d req60=%b exp=1/0", ok, virq_req60); end
    e = sb.pop_front();
    bus_read(DtAddr, d, ok);
    checks++; if (!ok || d !== {9'b0, e[6:0]}) begin failures++; $display("FAIL irq_data2 ok=%0d got=%h exp=%h", ok, d, {9'b0, e[6:0]}); end
  endtask

  task automatic test_overflow();
    logic [15:0] d; logic [7:0] e; bit ok;
    for (int i = 0; i < 9; i++) begin
      push_key(7'(8'h50 + i), 0);
      if (i < 8) sb.push_back(8'(8'h50 + i));
    end
    checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL ovf_level got=%0d exp=8", fifo_level); end
    bus_read(StAddr, d, ok);
    checks++; if (!ok || d !== 16'h80C8) begin failures++; $display("FAIL ovf_status1 ok=%0d got=%h exp=80C8", ok, d); end
    bus_read(StAddr, d, ok);
    checks++; if (!ok || d !== 16'h00C8) begin failures++; $display("FAIL ovf_status2 ok=%0d got=%h exp=00C8", ok, d); end
    // Data read and key push land on the same edge while full
    bus_sync = 1; bus_addr = DtAddr; bus_we = 0; bus_stb = 1;
    key_strobe = 1; key_code = 7'h59;
    tick();
    key_strobe = 0; key_code = '0;
    e = sb.pop_front(); sb.push_back(8'h59);
    checks++; if (bus_ack !== 1'b1 || bus_dout !== {9'b0, e[6:0]}) begin failures++; $display("FAIL sim_data ack=%b got=%h exp=%h", bus_ack, bus_dout, {9'b0, e[6:0]}); end
    bus_stb = 0; bus_sync = 0; bus_addr = '0;
    tick();
    checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL sim_level got=%0d exp=8", fifo_level); end
    bus_read(StAddr, d, ok);
    checks++; if (!ok || d !== 16'h00C8) begin failures++; $display("FAIL sim_status ok=%0d got=%h exp=00C8", ok, d); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus_read(DtAddr, d, ok);
      checks++; if (!ok || d !== {9'b0, e[6:0]}) begin failures++; $display("FAIL drain_data ok=%0d got=%h exp=%h", ok, d, {9'b0, e[6:0]}); end
    end
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL drain_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_repeat();
    logic [15:0] d; logic [7:0] e; bit ok; int exp_lvl;
    key_held = 1;
    push_key(7'h30, 0); sb.push_back(8'h30);
    exp_lvl = 1;
    for (int k = 1; k <= 28; k++) begin
      tick();
      if (k == 10 || k == 14 || k == 18) begin exp_lvl++; sb.push_back(8'h30); end
      checks++; if (fifo_level !== 4'(exp_lvl)) begin failures++; $display("FAIL repeat_level cyc=%0d got=%0d exp=%0d", k, fifo_level, exp_lvl); end
      if (k == 19) key_held = 0;
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus_read(DtAddr, d, ok);
      checks++; if (!ok || d !== {9'b0, e[6:0]}) begin failures++; $display("FAIL repeat_data ok=%0d got=%h exp=%h", ok, d, {9'b0, e[6:0]}); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; bit ok;
    bus_write(StAddr, 16'h0008, ok);
    key_held = 1;
    push_key(7'h31, 0); sb.push_back(8'h31);
    tick(); tick();
    checks++; if (virq_req60 !== 1'b1) begin failures++; $display("FAIL mid_req60 got=%b exp=1", virq_req60); end
    bus_reset = 1; tick(); bus_reset = 0;
    sb.delete();
    checks++; if (virq_req60 !== 1'b0 || virq_req274 !== 1'b0 || fifo_level !== 4'd0) begin
      failures++; $display("FAIL mid_reset req=%b%b level=%0d exp=00/0", virq_req60, virq_req274, fifo_level);
    end
    bus_read(StAddr, d, ok);
    checks++; if (!ok || d !== 16'h0048) begin failures++; $display("FAIL mid_status ok=%0d got=%h exp=0048", ok, d); end
    for (int i = 0; i < 14; i++) tick();
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL mid_no_repeat got=%0d exp=0", fifo_level); end
    key_held = 0;
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_irq();
    test_overflow();
    test_repeat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
